// File: rtl/pipe_stage_regs_pkg.sv
// rtl/pipe_stage_regs_pkg.sv - widths, boundary bundle types and bubble constants for the F/D, D/E and E/M registers
package pipe_stage_regs_pkg;

  localparam int DATA_W = 32;
  localparam int REG_W  = 5;
  localparam int ALUC_W = 3;

  typedef struct packed {
    logic [DATA_W-1:0] instr;
    logic [DATA_W-1:0] pc_plus4;
  } fd_bundle_t;

  typedef struct packed {
    logic              reg_write;
    logic              mem_to_reg;
    logic              mem_write;
    logic              mem_write_sb;
    logic              alu_src;
    logic              reg_dst;
    logic              jal;
    logic [ALUC_W-1:0] alu_control;
    logic [DATA_W-1:0] data1;
    logic [DATA_W-1:0] data2;
    logic [DATA_W-1:0] sign_imm;
    logic [DATA_W-1:0] pc_plus4;
    logic [REG_W-1:0]  rs;
    logic [REG_W-1:0]  rt;
    logic [REG_W-1:0]  rd;
    logic              sys;
    logic [DATA_W-1:0] regv;
    logic [DATA_W-1:0] rega;
  } de_bundle_t;

  typedef struct packed {
    logic              reg_write;
    logic              mem_to_reg;
    logic              mem_write;
    logic              mem_write_sb;
    logic              jal;
    logic              sys;
    logic [DATA_W-1:0] alu_out;
    logic [DATA_W-1:0] write_data;
    logic [DATA_W-1:0] pc_plus4;
    logic [DATA_W-1:0] regv;
    logic [DATA_W-1:0] rega;
    logic [REG_W-1:0]  write_reg;
  } em_bundle_t;

  // An all-zero bundle is a nop/bubble: no register write, no store, no jal, no syscall.
  localparam fd_bundle_t FD_BUBBLE = '0;
  localparam de_bundle_t DE_BUBBLE = '0;
  localparam em_bundle_t EM_BUBBLE = '0;

endpackage

// File: rtl/pipe_stage_regs_pipe_reg.sv
// rtl/pipe_stage_regs_pipe_reg.sv - width-parameterised flop with sync reset, enable and enable-qualified clear
module pipe_reg #(
  parameter int           W       = 1,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Clear only acts while enabled, so a hold beats a clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= RST_VAL;
    end else if (en) begin
      q <= clr ? RST_VAL : d;
    end
  end

endmodule

// File: rtl/pipe_stage_regs.sv
// rtl/pipe_stage_regs.sv - F/D, D/E, E/M pipeline registers with stall/flush; SYSCALL_TRACE_EN enables sys/regv/rega
module pipe_stage_regs
  import pipe_stage_regs_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              StallD,
  input  logic              PCSrcD,
  input  logic              FlushE,
  input  logic [DATA_W-1:0] InstrF,
  input  logic [DATA_W-1:0] PCPlus4F,
  output logic [DATA_W-1:0] InstrD,
  output logic [DATA_W-1:0] PCPlus4D,
  input  logic              RegWriteD,
  input  logic              MemtoRegD,
  input  logic              MemWriteD,
  input  logic              MemWriteSBD,
  input  logic              ALUSrcD,
  input  logic              RegDstD,
  input  logic              JalD,
  input  logic [ALUC_W-1:0] ALUControlD,
  input  logic [DATA_W-1:0] data1D,
  input  logic [DATA_W-1:0] data2D,
  input  logic [DATA_W-1:0] SignImmD,
  input  logic [REG_W-1:0]  RsD,
  input  logic [REG_W-1:0]  RtD,
  input  logic [REG_W-1:0]  RdD,
  input  logic              sysD,
  input  logic [DATA_W-1:0] regvD,
  input  logic [DATA_W-1:0] regaD,
  output logic              RegWriteE,
  output logic              MemtoRegE,
  output logic              MemWriteE,
  output logic              MemWriteSBE,
  output logic              ALUSrcE,
  output logic              RegDstE,
  output logic              JalE,
  output logic [ALUC_W-1:0] ALUControlE,
  output logic [DATA_W-1:0] data1E,
  output logic [DATA_W-1:0] data2E,
  output logic [DATA_W-1:0] SignImmE,
  output logic [DATA_W-1:0] PCPlus4E,
  output logic [REG_W-1:0]  RsE,
  output logic [REG_W-1:0]  RtE,
  output logic [REG_W-1:0]  RdE,
  output logic              sysE,
  output logic [DATA_W-1:0] regvE,
  output logic [DATA_W-1:0] regaE,
  input  logic [DATA_W-1:0] ALUInE,
  input  logic [DATA_W-1:0] WriteDataE,
  input  logic [REG_W-1:0]  WriteRegE,
  output logic              RegWriteM,
  output logic              MemtoRegM,
  output logic              MemWriteM,
  output logic              MemWriteSBM,
  output logic              JalM,
  output logic              sysM,
  output logic [DATA_W-1:0] ALUOutM,
  output logic [DATA_W-1:0] WriteDataM,
  output logic [DATA_W-1:0] PCPlus4M,
  output logic [DATA_W-1:0] regvM,
  output logic [DATA_W-1:0] regaM,
  output logic [REG_W-1:0]  WriteRegM
);

  fd_bundle_t fd_d, fd_q;
  de_bundle_t de_d, de_q;
  em_bundle_t em_d, em_q;

  assign fd_d.instr    = InstrF;
  assign fd_d.pc_plus4 = PCPlus4F;

  pipe_reg #(.W($bits(fd_bundle_t)), .RST_VAL(FD_BUBBLE)) u_fd (
    .clk (clk),
    .rst (rst),
    .en  (~StallD),
    .clr (PCSrcD),
    .d   (fd_d),
    .q   (fd_q)
  );

  assign InstrD   = fd_q.instr;
  assign PCPlus4D = fd_q.pc_plus4;

  assign de_d.reg_write    = RegWriteD;
  assign de_d.mem_to_reg   = MemtoRegD;
  assign de_d.mem_write    = MemWriteD;
  assign de_d.mem_write_sb = MemWriteSBD;
  assign de_d.alu_src      = ALUSrcD;
  assign de_d.reg_dst      = RegDstD;
  assign de_d.jal          = JalD;
  assign de_d.alu_control  = ALUControlD;
  assign de_d.data1        = data1D;
  assign de_d.data2        = data2D;
  assign de_d.sign_imm     = SignImmD;
  assign de_d.pc_plus4     = fd_q.pc_plus4;
  assign de_d.rs           = RsD;
  assign de_d.rt           = RtD;
  assign de_d.rd           = RdD;

`ifdef SYSCALL_TRACE_EN
  assign de_d.sys  = sysD;
  assign de_d.regv = regvD;
  assign de_d.rega = regaD;
`else
  // Trace fields are tied off; the inputs stay on the port list for a uniform interface.
  logic unused_trace;
  assign unused_trace = ^{sysD, regvD, regaD};
  assign de_d.sys  = 1'b0;
  assign de_d.regv = '0;
  assign de_d.rega = '0;
`endif

  pipe_reg #(.W($bits(de_bundle_t)), .RST_VAL(DE_BUBBLE)) u_de (
    .clk (clk),
    .rst (rst),
    .en  (1'b1),
    .clr (FlushE),
    .d   (de_d),
    .q   (de_q)
  );

  assign RegWriteE   = de_q.reg_write;
  assign MemtoRegE   = de_q.mem_to_reg;
  assign MemWriteE   = de_q.mem_write;
  assign MemWriteSBE = de_q.mem_write_sb;
  assign ALUSrcE     = de_q.alu_src;
  assign RegDstE     = de_q.reg_dst;
  assign JalE        = de_q.jal;
  assign ALUControlE = de_q.alu_control;
  assign data1E      = de_q.data1;
  assign data2E      = de_q.data2;
  assign SignImmE    = de_q.sign_imm;
  assign PCPlus4E    = de_q.pc_plus4;
  assign RsE         = de_q.rs;
  assign RtE         = de_q.rt;
  assign RdE         = de_q.rd;
  assign sysE        = de_q.sys;
  assign regvE       = de_q.regv;
  assign regaE       = de_q.rega;

  assign em_d.reg_write    = de_q.reg_write;
  assign em_d.mem_to_reg   = de_q.mem_to_reg;
  assign em_d.mem_write    = de_q.mem_write;
  assign em_d.mem_write_sb = de_q.mem_write_sb;
  assign em_d.jal          = de_q.jal;
  assign em_d.sys          = de_q.sys;
  assign em_d.alu_out      = ALUInE;
  assign em_d.write_data   = WriteDataE;
  assign em_d.pc_plus4     = de_q.pc_plus4;
  assign em_d.regv         = de_q.regv;
  assign em_d.rega         = de_q.rega;
  assign em_d.write_reg    = WriteRegE;

  pipe_reg #(.W($bits(em_bundle_t)), .RST_VAL(EM_BUBBLE)) u_em (
    .clk (clk),
    .rst (rst),
    .en  (1'b1),
    .clr (1'b0),
    .d   (em_d),
    .q   (em_q)
  );

  assign RegWriteM   = em_q.reg_write;
  assign MemtoRegM   = em_q.mem_to_reg;
  assign MemWriteM   = em_q.mem_write;
  assign MemWriteSBM = em_q.mem_write_sb;
  assign JalM        = em_q.jal;
  assign sysM        = em_q.sys;
  assign ALUOutM     = em_q.alu_out;
  assign WriteDataM  = em_q.write_data;
  assign PCPlus4M    = em_q.pc_plus4;
  assign regvM       = em_q.regv;
  assign regaM       = em_q.rega;
  assign WriteRegM   = em_q.write_reg;

endmodule

// File: tb/tb_pipe_stage_regs.sv
// tb/tb_pipe_stage_regs.sv - directed and randomized checks of pipe_stage_regs against a stage-level model
module tb_pipe_stage_regs;

`ifdef SYSCALL_TRACE_EN
  localparam bit TRACE = 1'b1;
`else
  localparam bit TRACE = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst, StallD, PCSrcD, FlushE;
  logic [31:0] InstrF, PCPlus4F, InstrD, PCPlus4D;
  logic RegWriteD, MemtoRegD, MemWriteD, MemWriteSBD, ALUSrcD, RegDstD, JalD, sysD;
  logic [2:0] ALUControlD, ALUControlE;
  logic [31:0] data1D, data2D, SignImmD, regvD, regaD;
  logic [4:0] RsD, RtD, RdD, RsE, RtE, RdE, WriteRegE, WriteRegM;
  logic RegWriteE, MemtoRegE, MemWriteE, MemWriteSBE, ALUSrcE, RegDstE, JalE, sysE;
  logic [31:0] data1E, data2E, SignImmE, PCPlus4E, regvE, regaE;
  logic [31:0] ALUInE, WriteDataE;
  logic RegWriteM, MemtoRegM, MemWriteM, MemWriteSBM, JalM, sysM;
  logic [31:0] ALUOutM, WriteDataM, PCPlus4M, regvM, regaM;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  pipe_stage_regs dut (
    .clk(clk), .rst(rst), .StallD(StallD), .PCSrcD(PCSrcD), .FlushE(FlushE),
    .InstrF(InstrF), .PCPlus4F(PCPlus4F), .InstrD(InstrD), .PCPlus4D(PCPlus4D),
    .RegWriteD(RegWriteD), .MemtoRegD(MemtoRegD), .MemWriteD(MemWriteD),
    .MemWriteSBD(MemWriteSBD), .ALUSrcD(ALUSrcD), .RegDstD(RegDstD), .JalD(JalD),
    .ALUControlD(ALUControlD), .data1D(data1D), .data2D(data2D), .SignImmD(SignImmD),
    .RsD(RsD), .RtD(RtD), .RdD(RdD), .sysD(sysD), .regvD(regvD), .regaD(regaD),
    .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE), .MemWriteE(MemWriteE),
    .MemWriteSBE(MemWriteSBE), .ALUSrcE(ALUSrcE), .RegDstE(RegDstE), .JalE(JalE),
    .ALUControlE(ALUControlE), .data1E(data1E), .data2E(data2E), .SignImmE(SignImmE),
    .PCPlus4E(PCPlus4E), .RsE(RsE), .RtE(RtE), .RdE(RdE), .sysE(sysE),
    .regvE(regvE), .regaE(regaE), .ALUInE(ALUInE), .WriteDataE(WriteDataE),
    .WriteRegE(WriteRegE), .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM),
    .MemWriteM(MemWriteM), .MemWriteSBM(MemWriteSBM), .JalM(JalM), .sysM(sysM),
    .ALUOutM(ALUOutM), .WriteDataM(WriteDataM), .PCPlus4M(PCPlus4M),
    .regvM(regvM), .regaM(regaM), .WriteRegM(WriteRegM)
  );

  // Reference model: what each stage should currently be presenting.
  logic [31:0] x_instrD, x_pc4D;
  logic x_rwE, x_m2rE, x_mwE, x_mwsbE, x_asE, x_rdstE, x_jalE, x_sysE;
  logic [2:0] x_aluE;
  logic [31:0] x_d1E, x_d2E, x_immE, x_pc4E, x_regvE, x_regaE;
  logic [4:0] x_rsE, x_rtE, x_rdE;
  logic x_rwM, x_m2rM, x_mwM, x_mwsbM, x_jalM, x_sysM;
  logic [31:0] x_aluM, x_wdM, x_pc4M, x_regvM, x_regaM;
  logic [4:0] x_wrM;

  logic [255:0] got_d, got_e, got_m, exp_d, exp_e, exp_m;
  assign got_d = {InstrD, PCPlus4D};
  assign exp_d = {x_instrD, x_pc4D};
  assign got_e = {RegWriteE, MemtoRegE, MemWriteE, MemWriteSBE, ALUSrcE, RegDstE, JalE, ALUControlE,
                  data1E, data2E, SignImmE, PCPlus4E, RsE, RtE, RdE, sysE, regvE, regaE};
  assign exp_e = {x_rwE, x_m2rE, x_mwE, x_mwsbE, x_asE, x_rdstE, x_jalE, x_aluE,
                  x_d1E, x_d2E, x_immE, x_pc4E, x_rsE, x_rtE, x_rdE, x_sysE, x_regvE, x_regaE};
  assign got_m = {RegWriteM, MemtoRegM, MemWriteM, MemWriteSBM, JalM, sysM,
                  ALUOutM, WriteDataM, PCPlus4M, regvM, regaM, WriteRegM};
  assign exp_m = {x_rwM, x_m2rM, x_mwM, x_mwsbM, x_jalM, x_sysM,
                  x_aluM, x_wdM, x_pc4M, x_regvM, x_regaM, x_wrM};

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic clear_d();
    x_instrD = 0; x_pc4D = 0;
  endtask

  task automatic clear_e();
    {x_rwE, x_m2rE, x_mwE, x_mwsbE, x_asE, x_rdstE, x_jalE, x_sysE} = 0;
    x_aluE = 0; x_d1E = 0; x_d2E = 0; x_immE = 0; x_pc4E = 0; x_regvE = 0; x_regaE = 0;
    x_rsE = 0; x_rtE = 0; x_rdE = 0;
  endtask

  task automatic clear_m();
    {x_rwM, x_m2rM, x_mwM, x_mwsbM, x_jalM, x_sysM} = 0;
    x_aluM = 0; x_wdM = 0; x_pc4M = 0; x_regvM = 0; x_regaM = 0; x_wrM = 0;
  endtask

  // Advance the model one clock from the current inputs; later stages first so each reads the older value.
  task automatic model_edge();
    if (rst) begin
      clear_d(); clear_e(); clear_m();
    end else begin
      x_rwM = x_rwE; x_m2rM = x_m2rE; x_mwM = x_mwE; x_mwsbM = x_mwsbE; x_jalM = x_jalE;
      x_sysM = x_sysE; x_aluM = ALUInE; x_wdM = WriteDataE; x_pc4M = x_pc4E;
      x_regvM = x_regvE; x_regaM = x_regaE; x_wrM = WriteRegE;
      if (FlushE) clear_e();
      else begin
        x_rwE = RegWriteD; x_m2rE = MemtoRegD; x_mwE = MemWriteD; x_mwsbE = MemWriteSBD;
        x_asE = ALUSrcD; x_rdstE = RegDstD; x_jalE = JalD; x_aluE = ALUControlD;
        x_d1E = data1D; x_d2E = data2D; x_immE = SignImmD; x_pc4E = x_pc4D;
        x_rsE = RsD; x_rtE = RtD; x_rdE = RdD;
        x_sysE  = TRACE ? sysD : 1'b0;
        x_regvE = TRACE ? regvD : 32'd0;
        x_regaE = TRACE ? regaD : 32'd0;
      end
      if (!StallD) begin
        if (PCSrcD) clear_d();
        else begin
          x_instrD = InstrF; x_pc4D = PCPlus4F;
        end
      end
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    chk("stage_D", got_d, exp_d);
    chk("stage_E", got_e, exp_e);
    chk("stage_M", got_m, exp_m);
  endtask

  task automatic rand_data();
    InstrF = $urandom; PCPlus4F = $urandom;
    {RegWriteD, MemtoRegD, MemWriteD, MemWriteSBD, ALUSrcD, RegDstD, JalD, sysD} = 8'($urandom);
    ALUControlD = 3'($urandom); data1D = $urandom; data2D = $urandom; SignImmD = $urandom;
    RsD = 5'($urandom); RtD = 5'($urandom); RdD = 5'($urandom);
    regvD = $urandom; regaD = $urandom;
    ALUInE = $urandom; WriteDataE = $urandom; WriteRegE = 5'($urandom);
  endtask

  task automatic ctl(input logic r, input logic s, input logic p, input logic f);
    rst = r; StallD = s; PCSrcD = p; FlushE = f;
  endtask

  initial begin
    clear_d(); clear_e(); clear_m();
    rand_data();
    ctl(1, 0, 0, 0);
    #2;

    rand_data();
    InstrF = 32'hDEAD_BEEF; RegWriteD = 1; ALUInE = 32'h55;
    step();
    chk("reset_D", got_d, 256'd0);
    chk("reset_E", got_e, 256'd0);
    chk("reset_M", got_m, 256'd0);

    ctl(0, 0, 0, 0);
    rand_data();
    InstrF = 32'h2010_0005; PCPlus4F = 32'h0040_0004; ALUInE = 32'h1234;
    step();
    chk("pass_instrD", InstrD, 32'h2010_0005);
    chk("pass_pc4D", PCPlus4D, 32'h0040_0004);
    chk("pass_aluoutM", ALUOutM, 32'h1234);

    InstrF = 32'hAAAA_0000;
    step();
    ctl(0, 1, 1, 0);
    InstrF = 32'hBBBB_0000;
    step();
    chk("stall_over_pcsrc", InstrD, 32'hAAAA_0000);

    ctl(0, 0, 1, 0);
    step();
    chk("branch_instrD", InstrD, 32'd0);
    chk("branch_pc4D", PCPlus4D, 32'd0);
    ctl(0, 0, 0, 0);
    InstrF = 32'h1111_2222;
    step();
    chk("after_branch", InstrD, 32'h1111_2222);

    ctl(0, 1, 0, 1);
    RegWriteD = 1; MemWriteD = 1; RsD = 5'd9;
    step();
    chk("bubble_rwE", RegWriteE, 1'b0);
    chk("bubble_mwE", MemWriteE, 1'b0);
    chk("bubble_rsE", RsE, 5'd0);
    chk("loaduse_hold", InstrD, 32'h1111_2222);
    ctl(0, 0, 0, 0);
    step();
    chk("bubble_rwM", RegWriteM, 1'b0);

    sysD = 1; regvD = 32'd10;
    step();
    step();
    chk("trace_sysM", sysM, TRACE ? 1'b1 : 1'b0);
    chk("trace_regvM", regvM, TRACE ? 32'd10 : 32'd0);

    for (int i = 0; i < 400; i++) begin
      rand_data();
      ctl($urandom_range(0, 39) == 0, $urandom_range(0, 4) == 0,
          $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0);
      step();
    end

    ctl(1, 0, 0, 0);
    rand_data();
    step();
    chk("midrun_reset_M", got_m, 256'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
